// File: rtl/axi_wr_slave_mem_if.sv
// AXI3 write-channel bundle (AW, W, B) between a write master and axi_wr_slave_mem.
interface axi_wr_slave_mem_if;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LEN_W  = 4;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_wr_slave_mem.sv
// AXI3 single-outstanding write responder over a word-addressed memory with a registered debug read port.
// Optional AXI_WR_SLAVE_STALL_EN: wready on alternate DATA cycles and bvalid delayed one cycle.
module axi_wr_slave_mem #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rstn,
  axi_wr_slave_mem_if.slave  axi,
  input  logic [ADDR_W-1:0]  dbg_addr,
  output logic [31:0]        dbg_rdata,
  output logic               busy
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned OFF_W  = 30;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_DATA = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              fixed_q, fixed_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              err_burst_q, err_burst_d;
  logic              err_q, err_d;

  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              busy_q, busy_d;

  logic              mem_we;
  logic [DATA_W-1:0] addr_rel;
  logic              aw_hs, w_hs, b_hs;
  logic              in_range, id_ok, cnt_last;

  logic [DATA_W-1:0] mem [DEPTH];

  assign addr_rel = axi.awaddr - BASE_ADDR;
  assign aw_hs    = awready_q & axi.awvalid;
  assign w_hs     = wready_q & axi.wvalid;
  assign b_hs     = bvalid_q & axi.bready;
  assign in_range = (off_q >> ADDR_W) == '0;
  assign id_ok    = axi.wid == id_q;
  assign cnt_last = cnt_q == len_q;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      id_q        <= '0;
      len_q       <= '0;
      fixed_q     <= 1'b0;
      off_q       <= '0;
      cnt_q       <= '0;
      err_burst_q <= 1'b0;
      err_q       <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= RESP_OKAY;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      len_q       <= len_d;
      fixed_q     <= fixed_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      err_burst_q <= err_burst_d;
      err_q       <= err_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      busy_q      <= busy_d;
    end
  end

  // Next state, burst bookkeeping and next output values
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    len_d       = len_q;
    fixed_d     = fixed_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    err_burst_d = err_burst_q;
    err_d       = err_q;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          id_d        = axi.awid;
          len_d       = axi.awlen;
          fixed_d     = axi.awburst == 2'b00;
          off_d       = addr_rel[DATA_W-1:2];
          cnt_d       = '0;
          err_burst_d = (axi.awsize != 3'b010) || axi.awburst[1] || (addr_rel[1:0] != 2'b00);
          err_d       = err_burst_d;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          if (!err_burst_q && in_range && id_ok) mem_we = 1'b1;
          else                                   err_d  = 1'b1;
          // Saturate so an offset near the top of the 30-bit space never wraps back into memory
          if (!fixed_q && (off_q != '1)) off_d = off_q + OFF_W'(1);
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_last != axi.wlast) err_d = 1'b1;
          if (cnt_last || axi.wlast) state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (b_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    awready_d = state_d == S_IDLE;
`ifdef AXI_WR_SLAVE_STALL_EN
    // wready_q doubles as the DATA toggle: cleared on entry, inverted every DATA cycle
    wready_d  = (state_d == S_DATA) && (state_q == S_DATA) && !wready_q;
    bvalid_d  = (state_d == S_RESP) && (state_q == S_RESP);
`else
    wready_d  = state_d == S_DATA;
    bvalid_d  = state_d == S_RESP;
`endif
    bid_d     = (state_d == S_RESP) ? id_q : '0;
    bresp_d   = (state_d == S_RESP && err_d) ? RESP_SLVERR : RESP_OKAY;
    busy_d    = state_d != S_IDLE;
  end

  // Byte-strobed commit at the W handshake edge
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (axi.wstrb[b]) mem[off_q[ADDR_W-1:0]][8*b +: 8] <= axi.wdata[8*b +: 8];
      end
    end
  end

  // Debug read returns pre-write data on a same-cycle collision
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dbg_rdata <= '0;
    else       dbg_rdata <= mem[dbg_addr];
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Self-checking bench for axi_wr_slave_mem: vector table of bursts, B scoreboard, backpressure and reset sequences.
module tb_axi_wr_slave_mem;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic              clk = 1'b0;
  logic              rstn;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_rdata;
  logic              busy;

  axi_wr_slave_mem_if axi();

  axi_wr_slave_mem #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0000_0000)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .axi       (axi),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [3:0]  wid;
    logic [29:0] word;
    logic [1:0]  lo;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          wlast_at;
    bit          lane;
    logic [31:0] dbase;
    logic [1:0]  exp_bresp;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [3:0] bid;
    logic [1:0] bresp;
    int         lat;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] exp_mem [int];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t_aw = 0;
  logic        bv_prev = 1'b0;
  vec_t        vecs [13];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lat(input int last_idx);
`ifdef AXI_WR_SLAVE_STALL_EN
    return 2 * last_idx + 4;
`else
    return last_idx + 2;
`endif
  endfunction

  function automatic vec_t mk(input logic [3:0] id, input logic [3:0] wid, input logic [29:0] word,
                              input logic [1:0] lo, input logic [3:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input int wlast_at, input bit lane,
                              input logic [31:0] dbase, input logic [1:0] bresp, input int elat);
    vec_t v;
    v.id = id; v.wid = wid; v.word = word; v.lo = lo; v.len = len; v.size = size;
    v.burst = burst; v.wlast_at = wlast_at; v.lane = lane; v.dbase = dbase;
    v.exp_bresp = bresp; v.exp_lat = elat;
    return v;
  endfunction

  // B channel monitor: latency on bvalid rise, id/resp on handshake
  always @(negedge clk) begin
    if (rstn) begin
      if (axi.bvalid && !bv_prev && sb.size() > 0 && sb[0].lat >= 0)
        chk("b_latency", 32'(cyc - t_aw), 32'(sb[0].lat));
      if (axi.bvalid && axi.bready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected: actual bid=%0h with no response pending", axi.bid);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("bid", 32'(axi.bid), 32'(e.bid));
          chk("bresp", 32'(axi.bresp), 32'(e.bresp));
        end
      end
    end
    bv_prev <= axi.bvalid;
  end

  // All drive tasks start and end 1 time unit after a rising edge
  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int   n = 0;
    logic got = 1'b0;
    axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
    axi.awvalid = 1'b1;
    while (!got && n < 100) begin
      @(negedge clk);
      got = axi.awready;
      if (got) t_aw = cyc;
      @(posedge clk);
      n++;
    end
    #1 axi.awvalid = 1'b0;
    if (!got) chk("aw_handshake", 32'(got), 32'd1);
  endtask

  task automatic send_beat(input logic [31:0] data, input logic [3:0] strb, input logic [3:0] wid,
                           input logic last);
    int   n = 0;
    logic got = 1'b0;
    axi.wdata = data; axi.wstrb = strb; axi.wid = wid; axi.wlast = last; axi.wvalid = 1'b1;
    while (!got && n < 100) begin
      @(negedge clk);
      got = axi.wready;
      @(posedge clk);
      n++;
    end
    #1 axi.wvalid = 1'b0;
    if (!got) chk("w_handshake", 32'(got), 32'd1);
  endtask

  task automatic wait_b_done();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("b_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_check(input int w, input logic [31:0] exp, input string nm);
    dbg_addr = ADDR_W'(w);
    @(posedge clk);
    @(negedge clk);
    chk(nm, dbg_rdata, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input longint unsigned w, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] cur;
    cur = exp_mem.exists(int'(w)) ? exp_mem[int'(w)] : 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
    exp_mem[int'(w)] = cur;
  endtask

  task automatic run_vec(input vec_t v);
    int nb;
    logic legal;
    sb.push_back('{bid: v.id, bresp: v.exp_bresp, lat: v.exp_lat});
    do_aw(v.id, {v.word, v.lo}, v.len, v.size, v.burst);
    nb = (v.wlast_at >= 0 && v.wlast_at < int'(v.len)) ? v.wlast_at + 1 : int'(v.len) + 1;
    legal = (v.size == 3'b010) && !v.burst[1] && (v.lo == 2'b00) && (v.wid == v.id);
    for (int i = 0; i < nb; i++) begin
      logic [31:0] data;
      logic [3:0]  strb;
      longint unsigned w;
      logic [7:0]  lane_byte;
      lane_byte = 8'(8'hAA + 8'h11 * i);
      data = v.lane ? (32'(lane_byte) << (8 * (i % 4))) : v.dbase + 32'(i);
      strb = v.lane ? 4'(1 << (i % 4)) : 4'hF;
      w = longint'(v.word) + ((v.burst == 2'b00) ? 0 : i);
      send_beat(data, strb, v.wid, i == v.wlast_at);
      if (legal && w < DEPTH) model_write(w, data, strb);
    end
    @(negedge clk);
    chk("wready_after_last", 32'(axi.wready), 32'd0);
    wait_b_done();
    for (int i = 0; i < nb; i++) begin
      longint unsigned w;
      w = longint'(v.word) + ((v.burst == 2'b00) ? 0 : i);
      if (w < DEPTH && exp_mem.exists(int'(w))) dbg_check(int'(w), exp_mem[int'(w)], "mem_word");
    end
    if (exp_mem.exists(0)) dbg_check(0, exp_mem[0], "mem_word0");
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_awready"}, 32'(axi.awready), 32'd0);
    chk({tag, "_wready"},  32'(axi.wready),  32'd0);
    chk({tag, "_bvalid"},  32'(axi.bvalid),  32'd0);
    chk({tag, "_bid"},     32'(axi.bid),     32'd0);
    chk({tag, "_bresp"},   32'(axi.bresp),   32'd0);
    chk({tag, "_busy"},    32'(busy),        32'd0);
    chk({tag, "_dbg"},     dbg_rdata,        32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        id  wid word          lo len size    burst wl  lane dbase         bresp   latency
    vecs[0]  = mk(3,  3,  30'd16,   0, 7,  3'b010, 2'b01, 7,  0, 32'h0000_1000, OKAY,   lat(7));
    vecs[1]  = mk(1,  1,  30'd0,    0, 4,  3'b010, 2'b01, 4,  0, 32'h0000_A000, OKAY,   -1);
    vecs[2]  = mk(2,  2,  30'd5,    0, 0,  3'b010, 2'b01, 0,  0, 32'h0000_0000, OKAY,   -1);
    vecs[3]  = mk(4,  4,  30'd5,    0, 3,  3'b010, 2'b00, 3,  1, 32'h0000_0000, OKAY,   lat(3));
    vecs[4]  = mk(5,  5,  30'd1022, 0, 3,  3'b010, 2'b01, 3,  0, 32'h0000_E000, SLVERR, lat(3));
    vecs[5]  = mk(6,  6,  30'd100,  0, 7,  3'b010, 2'b01, 2,  0, 32'h0000_2000, SLVERR, lat(2));
    vecs[6]  = mk(7,  7,  30'd100,  0, 7,  3'b001, 2'b01, 7,  0, 32'h0000_3000, SLVERR, lat(7));
    vecs[7]  = mk(8,  9,  30'd16,   0, 1,  3'b010, 2'b01, 1,  0, 32'h0000_4000, SLVERR, -1);
    vecs[8]  = mk(9,  9,  30'd400,  0, 1,  3'b010, 2'b01, -1, 0, 32'h0000_5000, SLVERR, lat(1));
    vecs[9]  = mk(10, 10, 30'd16,   2, 0,  3'b010, 2'b01, 0,  0, 32'h0000_7700, SLVERR, -1);
    vecs[10] = mk(11, 11, 30'd16,   0, 1,  3'b010, 2'b10, 1,  0, 32'h0000_7800, SLVERR, -1);
    vecs[11] = mk(12, 12, 30'd500,  0, 15, 3'b010, 2'b01, 15, 0, 32'h0000_6000, OKAY,   lat(15));
    vecs[12] = mk(13, 13, 30'h3FFF_FFFF, 0, 1, 3'b010, 2'b01, 1, 0, 32'h0000_7000, SLVERR, -1);

    rstn = 1'b0;
    dbg_addr = '0;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 1'b0;
    axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b1;

    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_awready", 32'(axi.awready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    for (int k = 0; k < 13; k++) run_vec(vecs[k]);

    // Backpressure: B held while a second AW waits
    axi.bready = 1'b0;
    sb.push_back('{bid: 4'h9, bresp: OKAY, lat: -1});
    do_aw(4'h9, {30'd600, 2'b00}, 4'd0, 3'b010, 2'b01);
    send_beat(32'h9999_0600, 4'hF, 4'h9, 1'b1);
    model_write(600, 32'h9999_0600, 4'hF);
    begin
      int n = 0;
      while (!axi.bvalid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("bp_bvalid_rise", 32'(axi.bvalid), 32'd1);
    end
    @(posedge clk);
    #1;
    axi.awid = 4'hA; axi.awaddr = {30'd601, 2'b00}; axi.awlen = 4'd0; axi.awsize = 3'b010;
    axi.awburst = 2'b01; axi.awvalid = 1'b1;
    sb.push_back('{bid: 4'hA, bresp: OKAY, lat: -1});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_bvalid", 32'(axi.bvalid), 32'd1);
      chk("bp_bid", 32'(axi.bid), 32'h9);
      chk("bp_bresp", 32'(axi.bresp), 32'(OKAY));
      chk("bp_awready", 32'(axi.awready), 32'd0);
      @(posedge clk);
      #1;
    end
    axi.bready = 1'b1;
    @(negedge clk);
    chk("bp_awready_at_b_hs", 32'(axi.awready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_awready_after_b_hs", 32'(axi.awready), 32'd1);
    @(posedge clk);
    #1 axi.awvalid = 1'b0;
    send_beat(32'hAAAA_0601, 4'hF, 4'hA, 1'b1);
    model_write(601, 32'hAAAA_0601, 4'hF);
    wait_b_done();
    dbg_check(600, exp_mem[600], "bp_word600");
    dbg_check(601, exp_mem[601], "bp_word601");

    // Reset during beat 4 of a 16-beat burst
    do_aw(4'h1, {30'd0, 2'b00}, 4'd15, 3'b010, 2'b01);
    for (int i = 0; i < 4; i++) begin
      send_beat(32'h0000_B000 + 32'(i), 4'hF, 4'h1, 1'b0);
      model_write(longint'(i), 32'h0000_B000 + 32'(i), 4'hF);
    end
    axi.wdata = 32'h0000_B004; axi.wstrb = 4'hF; axi.wid = 4'h1; axi.wlast = 1'b0; axi.wvalid = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    @(posedge clk);
    #1 axi.wvalid = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) dbg_check(i, exp_mem[i], "post_reset_word");
    run_vec(mk(14, 14, 30'd700, 0, 3, 3'b010, 2'b01, 3, 0, 32'h0000_C000, OKAY, lat(3)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
